game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter MOVE_DIV, default 1000000, clock cycles per move_tick.
REQ-002 Parameter BULLET_DIV, default 100000, clock cycles per bullet_tick.
REQ-003 Parameter FIRE_COOLDOWN, default 8, bullet_ticks that must elapse after a fire_pulse before the next fire_pulse is allowed.
REQ-004 iVGA_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 move_left, move_right, fire, pause  in  1 each  raw button levels.
REQ-007 remaining_enemies  in  4  live enemy count from the play datapath.
REQ-008 ship_hit  in  1  level; ship collided with an enemy or enemy shot.
REQ-009 state  out  3  IDLE=0, PLAY=1, PAUSED=2, WIN=3, LOSE=4.
REQ-010 move_tick, bullet_tick  out  1 each  one-cycle enables for ship and bullet motion.
REQ-011 fire_pulse  out  1  one-cycle bullet-spawn request.
REQ-012 move_l_en, move_r_en  out  1 each  qualified move direction, held valid only while move_tick=1.
REQ-013 clear_field  out  1  one-cycle request to reinitialise enemies, bullets and ship.
REQ-014 win, lose  out  1 each  levels, high in WIN or LOSE respectively.

Function
REQ-015 All outputs shall be registered.
REQ-016 Edge detect: rise_x = x & ~x_q, where x_q is x delayed one cycle; this applies to fire and pause.
REQ-017 IDLE -> PLAY on rise_fire, and clear_field=1 in the first PLAY cycle.
REQ-018 PLAY -> PAUSED on rise_pause; PAUSED -> PLAY on rise_pause.
REQ-019 PLAY -> LOSE on ship_hit=1.
REQ-020 PLAY -> WIN on remaining_enemies==0 when ship_hit=0; LOSE takes priority if both occur in the same cycle.
REQ-021 PLAY: rise_pause takes priority over the win and lose checks in the same cycle.
REQ-022 WIN or LOSE -> IDLE on rise_fire.
REQ-023 PAUSED, WIN and LOSE shall ignore remaining_enemies and ship_hit.
REQ-024 Move counter: 0..MOVE_DIV-1 and bullet counter: 0..BULLET_DIV-1 increment only in PLAY.
REQ-025 Both counters hold their value in PAUSED, and clear to 0 in IDLE, WIN and LOSE.
REQ-026 move_tick=1 for one cycle when the move counter wraps from MOVE_DIV-1 to 0; bullet_tick uses the bullet counter the same way.
REQ-027 move_l_en = move_left & ~move_right when move_tick=1, else 0.
REQ-028 move_r_en = move_right & ~move_left when move_tick=1, else 0; both buttons pressed gives no motion.
REQ-029 fire_pulse=1 in the cycle after rise_fire is sampled, only when state==PLAY and cooldown==0.
REQ-030 A fire_pulse loads cooldown with FIRE_COOLDOWN.
REQ-031 Cooldown decrements by 1 on each bullet_tick and saturates at 0; a fire_pulse load in the same cycle as a bullet_tick wins.
REQ-032 The rise_fire that starts the game (IDLE->PLAY) shall not produce a fire_pulse.
REQ-033 A rise_fire rejected by cooldown is dropped, not queued.
REQ-034 Held buttons produce no repeat edges.
REQ-035 No tick, fire_pulse or clear_field outside PLAY.
REQ-036 Leaving PLAY clears cooldown to 0.

Reset
REQ-037 On rst=1, asynchronously: state=IDLE; all outputs 0; counters 0; cooldown 0.
REQ-038 On rst=1, fire_q=1 and pause_q=1, so a button held through reset release generates no edge.
REQ-039 rst asserted mid-PLAY shall abort immediately to IDLE with no further ticks or pulses.

Verification
REQ-040 Reset, then fire 0->1 -> state=1 and clear_field=1 for exactly one cycle, with fire_pulse=0.
REQ-041 MOVE_DIV=4 and BULLET_DIV=2 in PLAY -> move_tick every 4th cycle and bullet_tick every 2nd cycle; move_left=1 -> move_l_en pulses with move_tick; move_left=move_right=1 -> no enable.
REQ-042 Pause edge at move counter=2 -> state=2 and no ticks; second pause edge -> state=1 and the next move_tick arrives 2 cycles later.
REQ-043 FIRE_COOLDOWN=2 with three fire edges, one per bullet_tick period -> fire_pulse on the 1st and 3rd edges only.
REQ-044 remaining_enemies=0 and ship_hit=1 in the same PLAY cycle -> state=4 and lose=1; then fire edge -> state=0.
REQ-045 fire held high across rst release -> state stays 0; rst pulsed mid-PLAY -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//
// Top-level game flow controller for a small shooter running on the VGA
// pixel clock.
//
// The FSM walks through these states:
//   IDLE -> PLAY -> (PAUSED <-> PLAY) -> WIN / LOSE -> IDLE
//
// While the game is in PLAY, two free-running dividers produce one-cycle
// motion strobes:
//   - move_tick for the ship
//   - bullet_tick for the bullets
// A cooldown, counted in bullet ticks, rate-limits fire_pulse.
//
// Every output is registered. The FSM state is exported directly on `state`
// so that external checkers can follow it. Strobe outputs are
// single-cycle enables with no handshake: a consumer samples them on the
// clock edge where they are high. Nothing is held or retried.
//
// Ports
//   iVGA_CLK           in   clock; all state changes happen on its rising edge
//   rst                in   asynchronous, active-high reset
//   move_left/right    in   raw button levels for ship direction
//   fire, pause        in   raw button levels; only their rising edges act
//   remaining_enemies  in   live enemy count; 0 means the field is cleared
//   ship_hit           in   level; the ship was hit
//   state              out  IDLE=0, PLAY=1, PAUSED=2, WIN=3, LOSE=4
//   move_tick          out  one-cycle ship-motion enable
//   bullet_tick        out  one-cycle bullet-motion enable
//   fire_pulse         out  one-cycle bullet-spawn request
//   move_l_en/r_en     out  qualified direction, valid only with move_tick
//   clear_field        out  one-cycle reinitialise request on game start
//   win, lose          out  levels, high while in WIN / LOSE
// ---------------------------------------------------------------------------
module game_sequencer #(
  parameter int MOVE_DIV      = 1000000,
  parameter int BULLET_DIV    = 100000,
  parameter int FIRE_COOLDOWN = 8
) (
  input  logic       iVGA_CLK,
  input  logic       rst,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       fire,
  input  logic       pause,
  input  logic [3:0] remaining_enemies,
  input  logic       ship_hit,
  output logic [2:0] state,
  output logic       move_tick,
  output logic       bullet_tick,
  output logic       fire_pulse,
  output logic       move_l_en,
  output logic       move_r_en,
  output logic       clear_field,
  output logic       win,
  output logic       lose
);

  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int BW = (BULLET_DIV > 1) ? $clog2(BULLET_DIV) : 1;
  localparam int CW = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

  localparam logic [MW-1:0] MOVE_LAST   = MW'(MOVE_DIV - 1);
  localparam logic [BW-1:0] BULLET_LAST = BW'(BULLET_DIV - 1);
  localparam logic [CW-1:0] COOL_LOAD   = CW'(FIRE_COOLDOWN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_PAUSED = 3'd2,
    S_WIN    = 3'd3,
    S_LOSE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          fire_q, pause_q;
  logic [MW-1:0] move_cnt_q, move_cnt_d;
  logic [BW-1:0] bullet_cnt_q, bullet_cnt_d;
  logic [CW-1:0] cool_q, cool_d;

  logic move_tick_q, move_tick_d;
  logic bullet_tick_q, bullet_tick_d;
  logic fire_pulse_q, fire_pulse_d;
  logic move_l_en_q, move_l_en_d;
  logic move_r_en_q, move_r_en_d;
  logic clear_field_q, clear_field_d;
  logic win_q, win_d;
  logic lose_q, lose_d;

  logic rise_fire, rise_pause;
  logic move_wrap, bullet_wrap;

  assign rise_fire  = fire & ~fire_q;
  assign rise_pause = pause & ~pause_q;
  assign move_wrap   = (move_cnt_q == MOVE_LAST);
  assign bullet_wrap = (bullet_cnt_q == BULLET_LAST);

  always_comb begin
    state_d       = state_q;
    move_cnt_d    = move_cnt_q;
    bullet_cnt_d  = bullet_cnt_q;
    cool_d        = cool_q;
    move_tick_d   = 1'b0;
    bullet_tick_d = 1'b0;
    fire_pulse_d  = 1'b0;
    move_l_en_d   = 1'b0;
    move_r_en_d   = 1'b0;
    clear_field_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        move_cnt_d   = '0;
        bullet_cnt_d = '0;
        cool_d       = '0;
        // The starting fire edge only launches the game; it never spawns a bullet.
        if (rise_fire) begin
          state_d       = S_PLAY;
          clear_field_d = 1'b1;
        end
      end

      S_PLAY: begin
        // Priority order: pause, then lose, then win.
        // Counters only advance, and strobes only fire, on cycles that stay
        // in PLAY. This keeps every tick and pulse inside the PLAY window.
        if (rise_pause) begin
          state_d = S_PAUSED;
          cool_d  = '0;
        end else if (ship_hit) begin
          state_d      = S_LOSE;
          move_cnt_d   = '0;
          bullet_cnt_d = '0;
          cool_d       = '0;
        end else if (remaining_enemies == 4'd0) begin
          state_d      = S_WIN;
          move_cnt_d   = '0;
          bullet_cnt_d = '0;
          cool_d       = '0;
        end else begin
          move_cnt_d    = move_wrap ? '0 : move_cnt_q + 1'b1;
          bullet_cnt_d  = bullet_wrap ? '0 : bullet_cnt_q + 1'b1;
          move_tick_d   = move_wrap;
          bullet_tick_d = bullet_wrap;
          move_l_en_d   = move_wrap & move_left & ~move_right;
          move_r_en_d   = move_wrap & move_right & ~move_left;
          // A rejected edge is simply dropped. A reload beats a decrement
          // that lands in the same cycle.
          if (rise_fire && (cool_q == '0)) begin
            fire_pulse_d = 1'b1;
            cool_d       = COOL_LOAD;
          end else if (bullet_wrap && (cool_q != '0)) begin
            cool_d = cool_q - 1'b1;
          end
        end
      end

      S_PAUSED: begin
        // Counters hold so that motion resumes at the same phase.
        if (rise_pause) begin
          state_d = S_PLAY;
        end
      end

      S_WIN, S_LOSE: begin
        move_cnt_d   = '0;
        bullet_cnt_d = '0;
        cool_d       = '0;
        if (rise_fire) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d      = S_IDLE;
        move_cnt_d   = '0;
        bullet_cnt_d = '0;
        cool_d       = '0;
      end
    endcase

    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  // The edge-detect registers reset high, so a button that is held through
  // reset release does not register as a fresh press.
  always_ff @(posedge iVGA_CLK or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fire_q        <= 1'b1;
      pause_q       <= 1'b1;
      move_cnt_q    <= '0;
      bullet_cnt_q  <= '0;
      cool_q        <= '0;
      move_tick_q   <= 1'b0;
      bullet_tick_q <= 1'b0;
      fire_pulse_q  <= 1'b0;
      move_l_en_q   <= 1'b0;
      move_r_en_q   <= 1'b0;
      clear_field_q <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fire_q        <= fire;
      pause_q       <= pause;
      move_cnt_q    <= move_cnt_d;
      bullet_cnt_q  <= bullet_cnt_d;
      cool_q        <= cool_d;
      move_tick_q   <= move_tick_d;
      bullet_tick_q <= bullet_tick_d;
      fire_pulse_q  <= fire_pulse_d;
      move_l_en_q   <= move_l_en_d;
      move_r_en_q   <= move_r_en_d;
      clear_field_q <= clear_field_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
    end
  end

  assign state       = state_q;
  assign move_tick   = move_tick_q;
  assign bullet_tick = bullet_tick_q;
  assign fire_pulse  = fire_pulse_q;
  assign move_l_en   = move_l_en_q;
  assign move_r_en   = move_r_en_q;
  assign clear_field = clear_field_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule
